// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the digit-serial multiplier controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  function automatic int digit_count(input int w);
    return w / DIGIT_W;
  endfunction

  function automatic bit legal_w(input int w);
    return (w >= 4) && (w <= 16) && ((w % DIGIT_W) == 0);
  endfunction

endpackage

// File: rtl/mult4_seq_ctrl_if.sv
// Operand/result handshake bundle between a source/sink and mult4_seq_ctrl.
interface mult4_seq_ctrl_if
  import mult_pkg::*;
#(
  parameter int W = 8
) ();

  // Both channels transfer on a rising edge where valid && ready; a valid
  // side keeps its payload stable until that edge, ready may change freely.
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;
  state_t         dbg_state;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy, dbg_state
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy, dbg_state
  );

endinterface

// File: rtl/main.sv
// Combinational 4x4 unsigned multiplier core producing the exact 8-bit digit product.
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);

    assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Computes a W x W unsigned product by stepping one radix-16 digit pair per
// cycle through a single shared 4x4 core and accumulating shifted partials.
module mult4_seq_ctrl
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mult4_seq_ctrl_if.slave  bus
);

    localparam int D  = digit_count(W);
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * W;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    if (!legal_w(W)) begin : g_w_check
        $error("mult4_seq_ctrl: W must be a multiple of 4 in 4..16");
    end

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [PW-1:0]   acc;
    logic [IW-1:0]   i_r;
    logic [IW-1:0]   j_r;
    logic            accept;
    logic            zero_op;
    logic            last_digit;
    logic [3:0]      x;
    logic [3:0]      y;
    logic [7:0]      core_o;
    logic [PW-1:0]   partial;

    assign accept     = (state == IDLE) && bus.in_valid;
    assign zero_op    = (bus.in_a == '0) || (bus.in_b == '0);
    assign last_digit = (i_r == LAST) && (j_r == LAST);

    // Digit selection and weighting of the core output by 16^(i+j).
    always_comb begin
        x       = 4'(a_r >> (DIGIT_W * int'(i_r)));
        y       = 4'(b_r >> (DIGIT_W * int'(j_r)));
        partial = PW'(core_o) << (DIGIT_W * (int'(i_r) + int'(j_r)));
    end

    main u_core (
        .x (x),
        .y (y),
        .o (core_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = zero_op ? DONE : MUL;
            MUL:     if (last_digit) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Index walk: j is the inner digit, i the outer; both return to 0 after the last pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            i_r <= '0;
            j_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r <= bus.in_a;
                        b_r <= bus.in_b;
                        acc <= '0;
                        i_r <= '0;
                        j_r <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + partial;
                    if (j_r == LAST) begin
                        j_r <= '0;
                        i_r <= (i_r == LAST) ? '0 : i_r + IW'(1);
                    end else begin
                        j_r <= j_r + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_p     = acc;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed and random checks of mult4_seq_ctrl at W=8, W=16 and W=4.
module tb_mult4_seq_ctrl;
  import mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp8_q[$];
  logic [31:0] exp16_q[$];
  logic [7:0]  exp4_q[$];

  mult4_seq_ctrl_if #(.W(8))  bus8 ();
  mult4_seq_ctrl_if #(.W(16)) bus16 ();
  mult4_seq_ctrl_if #(.W(4))  bus4 ();

  mult4_seq_ctrl #(.W(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mult4_seq_ctrl #(.W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  mult4_seq_ctrl #(.W(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- W=8 driver ----------------
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int stall, input string tag);
    logic [15:0] e;
    int k;
    k = 0;
    while (bus8.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " ready_before"}, 64'(bus8.in_ready), 64'd1);
    bus8.in_a      = a;
    bus8.in_b      = b;
    bus8.in_valid  = 1'b1;
    bus8.out_ready = (stall == 0);
    exp8_q.push_back(16'(a) * 16'(b));
    @(negedge clk);
    bus8.in_valid = 1'b0;
    bus8.in_a     = 8'($urandom);
    bus8.in_b     = 8'($urandom);
    k = 1;
    while (bus8.out_valid !== 1'b1 && k <= 40) begin
      chk({tag, " ready_low_mul"}, 64'(bus8.in_ready), 64'd0);
      chk({tag, " busy_mul"}, 64'(bus8.busy), 64'd1);
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 64'(k), ((a == 0) || (b == 0)) ? 64'd1 : 64'd5);
    chk({tag, " ready_low_done"}, 64'(bus8.in_ready), 64'd0);
    chk({tag, " busy_done"}, 64'(bus8.busy), 64'd1);
    chk({tag, " queue_nonempty"}, 64'(exp8_q.size() != 0), 64'd1);
    e = (exp8_q.size() != 0) ? exp8_q.pop_front() : 16'hxxxx;
    chk({tag, " product"}, 64'(bus8.out_p), 64'(e));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " stall_valid"}, 64'(bus8.out_valid), 64'd1);
      chk({tag, " stall_hold"}, 64'(bus8.out_p), 64'(e));
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, " post_valid"}, 64'(bus8.out_valid), 64'd0);
    chk({tag, " post_ready"}, 64'(bus8.in_ready), 64'd1);
    chk({tag, " post_busy"}, 64'(bus8.busy), 64'd0);
    chk({tag, " post_state"}, 64'(bus8.dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [31:0] e16;
    logic [7:0]  e4;
    logic [3:0]  a4;
    logic [3:0]  b4;

    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.in_a = '0;  bus8.in_b = '0;  bus8.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.out_ready = 1'b0;
    bus4.in_valid = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;  bus4.out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst w8 in_ready", 64'(bus8.in_ready), 64'd1);
    chk("rst w8 out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst w8 busy", 64'(bus8.busy), 64'd0);
    chk("rst w8 out_p", 64'(bus8.out_p), 64'd0);
    chk("rst w16 out_p", 64'(bus16.out_p), 64'd0);
    chk("rst w4 in_ready", 64'(bus4.in_ready), 64'd1);
    chk("rst w8 state", 64'(bus8.dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid pulse is the only way in; without it IDLE stays put
    repeat (3) @(negedge clk);
    chk("idle hold state", 64'(bus8.dbg_state), 64'(IDLE));

    op8(8'hFF, 8'hFF, 0, "w8 ff*ff");
    op8(8'h00, 8'h5A, 0, "w8 zero skip");
    op8(8'h0F, 8'h10, 10, "w8 stall");
    op8(8'hA5, 8'h00, 2, "w8 zero b stall");

    // abort mid-MUL with an asynchronous reset pulse
    bus8.in_a = 8'h12; bus8.in_b = 8'h34; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.in_valid = 1'b0;
    chk("abort state mul1", 64'(bus8.dbg_state), 64'(MUL));
    @(negedge clk);
    chk("abort state mul2", 64'(bus8.dbg_state), 64'(MUL));
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", 64'(bus8.in_ready), 64'd1);
    chk("abort out_valid", 64'(bus8.out_valid), 64'd0);
    chk("abort busy", 64'(bus8.busy), 64'd0);
    chk("abort out_p", 64'(bus8.out_p), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort idle after", 64'(bus8.dbg_state), 64'(IDLE));
    op8(8'h03, 8'h05, 0, "w8 after abort");

    // W=16 back-to-back with in_valid held high
    bus16.out_ready = 1'b1;
    chk("w16 ready first", 64'(bus16.in_ready), 64'd1);
    bus16.in_a = 16'hFFFF; bus16.in_b = 16'hFFFF; bus16.in_valid = 1'b1;
    exp16_q.push_back(32'hFFFE0001);
    @(negedge clk);
    bus16.in_a = 16'h1234; bus16.in_b = 16'h5678;
    k = 1;
    while (bus16.out_valid !== 1'b1 && k <= 40) begin
      @(negedge clk);
      k++;
    end
    chk("w16 lat first", 64'(k), 64'd17);
    e16 = (exp16_q.size() != 0) ? exp16_q.pop_front() : 32'hxxxxxxxx;
    chk("w16 prod first", 64'(bus16.out_p), 64'(e16));
    @(negedge clk);
    chk("w16 ready second", 64'(bus16.in_ready), 64'd1);
    chk("w16 valid gap", 64'(bus16.out_valid), 64'd0);
    exp16_q.push_back(32'h06260060);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    k = 1;
    while (bus16.out_valid !== 1'b1 && k <= 40) begin
      chk("w16 busy mul", 64'(bus16.busy), 64'd1);
      @(negedge clk);
      k++;
    end
    chk("w16 lat second", 64'(k), 64'd17);
    e16 = (exp16_q.size() != 0) ? exp16_q.pop_front() : 32'hxxxxxxxx;
    chk("w16 prod second", 64'(bus16.out_p), 64'(e16));
    @(negedge clk);
    chk("w16 ready end", 64'(bus16.in_ready), 64'd1);

    // W=4 random sweep against a*b
    bus4.out_ready = 1'b1;
    for (int n = 0; n < 256; n++) begin
      a4 = (n == 0) ? 4'hF : 4'($urandom_range(0, 15));
      b4 = (n == 0) ? 4'hF : 4'($urandom_range(0, 15));
      k = 0;
      while (bus4.in_ready !== 1'b1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      bus4.in_a = a4; bus4.in_b = b4; bus4.in_valid = 1'b1;
      exp4_q.push_back(8'(a4) * 8'(b4));
      @(negedge clk);
      bus4.in_valid = 1'b0;
      k = 1;
      while (bus4.out_valid !== 1'b1 && k <= 20) begin
        @(negedge clk);
        k++;
      end
      chk("w4 latency", 64'(k), ((a4 == 0) || (b4 == 0)) ? 64'd1 : 64'd2);
      e4 = (exp4_q.size() != 0) ? exp4_q.pop_front() : 8'hxx;
      chk("w4 product", 64'(bus4.out_p), 64'(e4));
      @(negedge clk);
    end
    chk("w4 queue drained", 64'(exp4_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult4_seq_ctrl.md
Name: mult4_seq_ctrl

Overview:
- Sequential controller that time-shares one 4x4 unsigned multiplier core to compute a W x W unsigned product, one radix-16 digit pair per cycle.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Owns the digit-index FSM, operand capture, shift/accumulate and result hold.
- Used wherever a wide product is needed at low area, in place of a full-width combinational array.

Parameters:
- W, 8, operand width in bits; multiple of 4, legal range 4..16.
- D, W/4 (derived, not overridable), digits per operand.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept operands.
- in_a  in  W  multiplicand, unsigned.
- in_b  in  W  multiplier, unsigned.
- out_valid  out  1  product available.
- out_ready  in  1  sink accepts product.
- out_p  out  2W  product in_a*in_b, unsigned.
- busy  out  1  high in MUL or DONE.

Behaviour:
- Reset is asynchronous and active-low, on a single clock. While rst_n=0:
  - state=IDLE, in_ready=1, out_valid=0, busy=0;
  - out_p=0, accumulator=0, digit indices i=j=0, captured operands=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, capture in_a/in_b into A_r/B_r and clear the accumulator. If either captured operand is 0, go to DONE with product 0 (zero skip). Otherwise go to MUL with i=j=0.
  - MUL: in_ready=0. Each cycle:
    - core inputs x=A_r[4i+3:4i], y=B_r[4j+3:4j];
    - acc <= acc + (core_out << 4*(i+j)), addition 2W bits wide, no overflow possible;
    - j increments, and on wrap j->0 then i increments;
    - after the cycle with i=j=D-1, go to DONE.
    - MUL lasts exactly D*D cycles (4 for W=8, 16 for W=16).
  - DONE: out_valid=1, out_p=acc. Hold out_p stable while out_valid&!out_ready. On out_valid&out_ready, go to IDLE, with out_valid=0 the next cycle.
- Latency from the accept edge to out_valid: D*D+1 cycles for nonzero operands, 1 cycle for the zero skip.
- No input acceptance in MUL or DONE: in_ready=0, and in_a/in_b are ignored and may change freely.
- Throughput: one result per D*D+2 cycles with no backpressure. Back-to-back accept only from IDLE; there is no accept in the same cycle as the out handshake.
- out_p is driven from the accumulator register only; no combinational path from inputs to outputs.
- in_valid may drop without accept; no state change in IDLE.
- Reset asserted mid-MUL or mid-DONE aborts the operation immediately. The pending result is lost, and the first cycle after rst_n rises is IDLE with in_ready=1.
- Core output: 8 bits, exact digit product (max 0xE1). The core is purely combinational and is used in the same cycle it is driven.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum {IDLE, MUL, DONE};
  - constant DIGIT_W=4;
  - function for the digit count (W/4);
  - the legal-W check used by an elaboration assertion.
- One sub-module: the existing 4x4 multiplier core (module main, ports x[3:0], y[3:0], o[7:0]), instantiated once.
- Digit-index counter and accumulator stay inline in mult4_seq_ctrl.

Test Plan:
- W=8, in_a=0xFF, in_b=0xFF, out_ready=1:
  - in_ready low for 5 cycles;
  - out_valid rises exactly 5 cycles after the accept edge with out_p=0xFE01;
  - in_ready=1 the cycle after the out handshake.
- W=8, in_a=0x00, in_b=0x5A:
  - zero skip: out_valid 1 cycle after accept, out_p=0x0000, busy high 1 cycle in DONE only.
- W=8, in_a=0x0F, in_b=0x10, out_ready=0 for 10 cycles then 1:
  - out_p=0x00F0 held stable with out_valid=1 throughout the stall;
  - single handshake, then IDLE.
- W=8, accept 0x12*0x34, assert rst_n=0 on the 2nd MUL cycle for 1 cycle:
  - all outputs at reset values asynchronously;
  - next accept of 0x03*0x05 yields 0x000F with no residue from the aborted operation.
- W=16, back-to-back pairs (0xFFFF,0xFFFF), (0x1234,0x5678), in_valid held high:
  - products 0xFFFE0001 and 0x06260060;
  - each out_valid 17 cycles after its accept;
  - second accept 1 cycle after the first out handshake.
- W=4, random 256-pair sweep vs reference model:
  - every product exact;
  - MUL lasts exactly 1 cycle for nonzero operands.
